// File: rtl/ex_wide_add_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_wide_add_seq_if : request/result handshake bundle for ex_wide_add_seq
// Revision: 1.0
// ---------------------------------------------------------------------------
interface ex_wide_add_seq_if #(
   parameter int W = 180
);
   logic         reqValid;
   logic         reqReady;
   logic [1:0]   reqOp;
   logic [W-1:0] reqA;
   logic [W-1:0] reqB;
   logic         reqCin;
   logic         resValid;
   logic         resReady;
   logic [W-1:0] resVal;
   logic         resCarry;

   modport master (
      output reqValid, reqOp, reqA, reqB, reqCin, resReady,
      input  reqReady, resValid, resVal, resCarry
   );

   modport slave (
      input  reqValid, reqOp, reqA, reqB, reqCin, resReady,
      output reqReady, resValid, resVal, resCarry
   );
endinterface
`default_nettype wire

// File: rtl/ex_wide_add_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ex_wide_add_seq : wide ADD/SUB/RSB/ADC by looping one 90-bit adder over slices
// Revision: 1.0
// ---------------------------------------------------------------------------
module ex_wide_add_seq #(
   parameter int PASSES = 2
) (
   input  wire logic         clock,
   input  wire logic         reset,
   ex_wide_add_seq_if.slave  bus
);
   localparam int SW = 90;
   localparam int W  = SW * PASSES;
   localparam int KW = (PASSES > 1) ? $clog2(PASSES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(PASSES - 1);

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_RSB = 2'b10;
   localparam logic [1:0] OP_ADC = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [1:0]    op;
   logic          carry;
   logic [KW-1:0] k;
   logic          res_valid;
   logic [W-1:0]  res_val;
   logic          res_carry;

   logic          req_fire;
   logic          b_inv;
   logic [SW:0]   sum0;
   logic [SW:0]   sum1;
   logic [SW:0]   sum;
   logic [SW-1:0] slice;
   logic [W-1:0]  res_next;

   assign bus.reqReady = (state == IDLE) && !reset;
   assign bus.resValid = res_valid;
   assign bus.resVal   = res_val;
   assign bus.resCarry = res_carry;

   assign req_fire = bus.reqValid && bus.reqReady;
   assign b_inv    = (bus.reqOp == OP_SUB) || (bus.reqOp == OP_RSB);

   // Carry-select: both carry-in outcomes are formed, the carry register picks one.
   assign sum0  = {1'b0, a_sh[SW-1:0]} + {1'b0, b_sh[SW-1:0]};
   assign sum1  = sum0 + (SW+1)'(1);
   assign sum   = carry ? sum1 : sum0;
   assign slice = (op == OP_RSB) ? ~sum[SW-1:0] : sum[SW-1:0];

   // Earlier slices wait in res_sh; the final pass writes the full word at once.
   if (PASSES == 1) begin : g_one_pass
      assign res_next = slice;
   end else begin : g_multi_pass
      logic [W-SW-1:0] res_sh;
      logic [W-1:0]    res_cat;

      assign res_cat  = {slice, res_sh};
      assign res_next = res_cat;

      always_ff @(posedge clock) begin
         if (reset) begin
            res_sh <= '0;
         end else if (state == RUN) begin
            res_sh <= res_cat[W-1:SW];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         a_sh      <= '0;
         b_sh      <= '0;
         op        <= OP_ADD;
         carry     <= 1'b0;
         k         <= '0;
         res_valid <= 1'b0;
         res_val   <= '0;
         res_carry <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  a_sh  <= bus.reqA;
                  b_sh  <= b_inv ? ~bus.reqB : bus.reqB;
                  op    <= bus.reqOp;
                  carry <= (bus.reqOp == OP_SUB) || ((bus.reqOp == OP_ADC) && bus.reqCin);
                  k     <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh  <= a_sh >> SW;
               b_sh  <= b_sh >> SW;
               // True-sum carry chains for every op, RSB included.
               carry <= sum[SW];
               if (k == K_LAST) begin
                  k         <= '0;
                  state     <= DONE;
                  res_valid <= 1'b1;
                  res_val   <= res_next;
                  res_carry <= sum[SW];
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               if (bus.resReady) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire
